// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: DEPTH chained slots with valid, stall and flush.
// Optional flush counter on bubble_cnt when PIPE_REG_BUBBLE_CNT_EN is defined.
module pipe_stage_reg #(
    parameter int DATA_W           = 96,
    parameter int DEPTH            = 1,
    parameter int KEEP_PC_ON_FLUSH = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WE,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [31:0]       instr_in,
    input  logic [31:0]       pc_in,
    input  logic [DATA_W-1:0] data_in,
`ifdef PIPE_REG_BUBBLE_CNT_EN
    output logic [15:0]       bubble_cnt,
`endif
    output logic              valid_out,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic [DATA_W-1:0] data_out
);

    localparam int D = (DEPTH < 1) ? 1 : ((DEPTH > 4) ? 4 : DEPTH);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("pipe_stage_reg: DEPTH must be in 1..4");
        end
    endgenerate

    typedef struct packed {
        logic              v;
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [DATA_W-1:0] data;
    } slot_t;

    slot_t slot_q [D];
    slot_t in_slot;
    slot_t flush_slot;

    always_comb begin
        in_slot       = '0;
        in_slot.v     = valid_in;
        in_slot.instr = instr_in;
        in_slot.pc    = pc_in;
        in_slot.data  = data_in;
    end

    // A killed slot may still carry its pc so the exception path can record EPC.
    always_comb begin
        flush_slot    = '0;
        flush_slot.pc = (KEEP_PC_ON_FLUSH != 0) ? pc_in : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < D; k++) slot_q[k] <= '0;
        end else if (flush) begin
            slot_q[0] <= flush_slot;
            for (int k = 1; k < D; k++) slot_q[k] <= '0;
        end else if (WE) begin
            slot_q[0] <= in_slot;
            for (int k = 1; k < D; k++) slot_q[k] <= slot_q[k-1];
        end
    end

    assign valid_out = slot_q[D-1].v;
    assign instr_out = slot_q[D-1].instr;
    assign pc_out    = slot_q[D-1].pc;
    assign data_out  = slot_q[D-1].data;

`ifdef PIPE_REG_BUBBLE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'h0;
        end else if (flush && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign bubble_cnt = cnt_q;
`endif

endmodule
